// File: rtl/panel_cmd_sequencer.sv
// panel_cmd_sequencer: queues front-panel command pulses and hands them to
// the CPU one at a time, arbitrating against the free-run (run) request.
//
// Ports:
//   clock, resetN                     clock, asynchronous active-low reset
//   loadpc_p/loadac_p/deposit_p/step_p single-cycle panel pulses
//   swreg[11:0]                       switch register, captured with the pulse
//   run                               panel run level
//   cpu_idle                          CPU is at an instruction boundary
//   cmd_ack                           CPU finished the presented command
//   cmd_valid, cmd_op[2:0], cmd_data  presented command (registered)
//   cpu_go                            CPU may free-run (registered)
//   busy                              FIFO non-empty or FSM not idle (combinational)
//   overflow                          sticky: a pulse was dropped
//   timeout                           sticky: a command was aborted
//
// Optional feature: define PANEL_SEQ_TIMEOUT_EN to add an ack watchdog of
// TIMEOUT_CYC cycles; without it CMD waits forever and timeout is tied 0.

module panel_cmd_sequencer #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic        loadpc_p,
   input  logic        loadac_p,
   input  logic        deposit_p,
   input  logic        step_p,
   input  logic [11:0] swreg,
   input  logic        run,
   input  logic        cpu_idle,
   input  logic        cmd_ack,
   output logic        cmd_valid,
   output logic [2:0]  cmd_op,
   output logic [11:0] cmd_data,
   output logic        cpu_go,
   output logic        busy,
   output logic        overflow,
   output logic        timeout
);

   localparam int unsigned DATA_W  = 12;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned ENTRY_W = OP_W + DATA_W;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMD  = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] STOP = 2'd3;

   localparam logic [2:0] OP_NONE    = 3'b000;
   localparam logic [2:0] OP_LOADPC  = 3'b001;
   localparam logic [2:0] OP_LOADAC  = 3'b010;
   localparam logic [2:0] OP_DEPOSIT = 3'b011;
   localparam logic [2:0] OP_STEP    = 3'b100;

   logic [1:0]         state, state_next;
   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               fifo_empty, fifo_full;
   logic               push, pop, drop;
   logic [2:0]         pulse_op;
   logic [2:0]         pulse_cnt;
   logic [ENTRY_W-1:0] head;
   logic               valid_next, go_next, tmo_hit;
   logic [OP_W-1:0]    op_next;
   logic [DATA_W-1:0]  data_next;

   // Priority pick among simultaneous pulses; losers count as drops.
   always_comb begin
      pulse_op = OP_NONE;
      if (loadpc_p)       pulse_op = OP_LOADPC;
      else if (loadac_p)  pulse_op = OP_LOADAC;
      else if (deposit_p) pulse_op = OP_DEPOSIT;
      else if (step_p)    pulse_op = OP_STEP;
      pulse_cnt = 3'(loadpc_p) + 3'(loadac_p) + 3'(deposit_p) + 3'(step_p);
   end

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign push       = (pulse_op != OP_NONE) && !fifo_full;
   assign drop       = (pulse_cnt > 3'd1) || ((pulse_op != OP_NONE) && fifo_full);
   assign head       = mem[rd_ptr];
   assign busy       = !fifo_empty || (state != IDLE);

   // FIFO storage; contents need no reset, validity is tracked by count.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {pulse_op, swreg};
   end

   // FIFO pointers wrap naturally since depth is a power of two.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      valid_next = 1'b0;
      op_next    = OP_NONE;
      data_next  = '0;
      go_next    = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_next = CMD;
               valid_next = 1'b1;
               op_next    = head[ENTRY_W-1 -: OP_W];
               data_next  = head[DATA_W-1:0];
            end else if (run) begin
               state_next = RUN;
               go_next    = 1'b1;
            end
         end
         CMD: begin
            if (cmd_ack || tmo_hit) begin
               pop        = 1'b1;
               state_next = IDLE;
            end else begin
               valid_next = 1'b1;
               op_next    = cmd_op;
               data_next  = cmd_data;
            end
         end
         RUN: begin
            if (!run || !fifo_empty) state_next = STOP;
            else                     go_next    = 1'b1;
         end
         STOP: begin
            if (cpu_idle) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state     <= IDLE;
         cmd_valid <= 1'b0;
         cmd_op    <= OP_NONE;
         cmd_data  <= '0;
         cpu_go    <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_next;
         cmd_valid <= valid_next;
         cmd_op    <= op_next;
         cmd_data  <= data_next;
         cpu_go    <= go_next;
         overflow  <= overflow | drop;
      end
   end

`ifdef PANEL_SEQ_TIMEOUT_EN
   localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC) + 1;

   logic [TCNT_W-1:0] tcnt;

   // Counts cycles spent in CMD; zero outside CMD so each entry starts fresh.
   assign tmo_hit = (state == CMD) && (tcnt == TCNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         tcnt    <= '0;
         timeout <= 1'b0;
      end else begin
         tcnt    <= (state == CMD && state_next == CMD) ? tcnt + TCNT_W'(1) : '0;
         timeout <= timeout | (tmo_hit && !cmd_ack);
      end
   end
`else
   logic unused_timeout_cfg;

   assign tmo_hit            = 1'b0;
   assign timeout            = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

endmodule

// File: tb/tb_panel_cmd_sequencer.sv
// tb_panel_cmd_sequencer: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based behavioural model of the sequencer.

module tb_panel_cmd_sequencer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 16;
   localparam int M_IDLE = 0;
   localparam int M_CMD  = 1;
   localparam int M_RUN  = 2;
   localparam int M_STOP = 3;

   logic        clock     = 1'b0;
   logic        resetN    = 1'b0;
   logic        loadpc_p  = 1'b0;
   logic        loadac_p  = 1'b0;
   logic        deposit_p = 1'b0;
   logic        step_p    = 1'b0;
   logic [11:0] swreg     = '0;
   logic        run       = 1'b0;
   logic        cpu_idle  = 1'b0;
   logic        cmd_ack   = 1'b0;
   logic        cmd_valid;
   logic [2:0]  cmd_op;
   logic [11:0] cmd_data;
   logic        cpu_go;
   logic        busy;
   logic        overflow;
   logic        timeout;

   always #5 clock = ~clock;

   panel_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clock(clock), .resetN(resetN),
      .loadpc_p(loadpc_p), .loadac_p(loadac_p), .deposit_p(deposit_p), .step_p(step_p),
      .swreg(swreg), .run(run), .cpu_idle(cpu_idle), .cmd_ack(cmd_ack),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .cpu_go(cpu_go), .busy(busy), .overflow(overflow), .timeout(timeout)
   );

   typedef struct packed {
      logic [2:0]  op;
      logic [11:0] data;
   } entry_t;

   entry_t q[$];
   entry_t cur;
   int     mode;
   int     m_wait;
   logic   m_ovf, m_tmo;
   int     checks = 0;
   int     errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mode   = M_IDLE;
      cur    = '0;
      m_wait = 0;
      m_ovf  = 1'b0;
      m_tmo  = 1'b0;
   endtask

   // One rising edge of the reference: decisions use the queue as it was before the edge.
   task automatic model_edge();
      int     old;
      int     n;
      bit     do_pop;
      entry_t e;
      if (!resetN) begin
         model_reset();
         return;
      end
      old    = q.size();
      do_pop = 0;
      n = int'(loadpc_p) + int'(loadac_p) + int'(deposit_p) + int'(step_p);
      case (mode)
         M_IDLE: begin
            if (old > 0) begin
               mode = M_CMD; cur = q[0]; m_wait = 0;
            end else if (run) mode = M_RUN;
         end
         M_CMD: begin
            if (cmd_ack) begin
               do_pop = 1; mode = M_IDLE;
            end
`ifdef PANEL_SEQ_TIMEOUT_EN
            else if (m_wait == TMO - 1) begin
               do_pop = 1; m_tmo = 1'b1; mode = M_IDLE;
            end else m_wait++;
`endif
         end
         M_RUN:   if (!run || old > 0) mode = M_STOP;
         default: if (cpu_idle) mode = M_IDLE;
      endcase
      if (n > 1) m_ovf = 1'b1;
      if (n > 0) begin
         if (old == DEPTH) m_ovf = 1'b1;
         else begin
            e.data = swreg;
            e.op   = loadpc_p ? 3'd1 : loadac_p ? 3'd2 : deposit_p ? 3'd3 : 3'd4;
            q.push_back(e);
         end
      end
      if (do_pop) void'(q.pop_front());
   endtask

   task automatic check_outputs();
      check_val("cmd_valid", 32'(cmd_valid), 32'(mode == M_CMD));
      check_val("cmd_op",    32'(cmd_op),    (mode == M_CMD) ? 32'(cur.op)   : 32'd0);
      check_val("cmd_data",  32'(cmd_data),  (mode == M_CMD) ? 32'(cur.data) : 32'd0);
      check_val("cpu_go",    32'(cpu_go),    32'(mode == M_RUN));
      check_val("busy",      32'(busy),      32'(q.size() > 0 || mode != M_IDLE));
      check_val("overflow",  32'(overflow),  32'(m_ovf));
      check_val("timeout",   32'(timeout),   32'(m_tmo));
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic clear_inputs();
      loadpc_p = 0; loadac_p = 0; deposit_p = 0; step_p = 0;
      run = 0; cpu_idle = 0; cmd_ack = 0; swreg = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      resetN = 1'b0;
      model_reset();
      tick();
      tick();
      resetN = 1'b1;
   endtask

   task automatic pulse(input int which, input logic [11:0] sw);
      swreg     = sw;
      loadpc_p  = (which == 1);
      loadac_p  = (which == 2);
      deposit_p = (which == 3);
      step_p    = (which == 4);
      tick();
      loadpc_p = 0; loadac_p = 0; deposit_p = 0; step_p = 0;
   endtask

   task automatic ack_once();
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
   endtask

   task automatic wait_for_valid(input string tag);
      int n = 0;
      while (cmd_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check_val(tag, 32'(cmd_valid), 32'd1);
   endtask

   task automatic wait_for_go(input string tag);
      int n = 0;
      while (cpu_go !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check_val(tag, 32'(cpu_go), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      int exp_ops[4] = '{2, 3, 4, 1};
      int ack_pct[6]   = '{30, 60, 0, 15, 80, 5};
      int pulse_pct[6] = '{10, 25, 30, 5, 40, 15};

      // Reset state
      model_reset();
      tick();
      check_val("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check_val("rst_cmd_op",    32'(cmd_op),    32'd0);
      check_val("rst_busy",      32'(busy),      32'd0);
      tick();
      resetN = 1'b1;
      tick();

      // Single deposit: valid two edges after the pulse, clears on ack
      pulse(3, 12'o1234);
      tick();
      check_val("dep_valid", 32'(cmd_valid), 32'd1);
      check_val("dep_op",    32'(cmd_op),    32'd3);
      check_val("dep_data",  32'(cmd_data),  32'(12'o1234));
      tick();
      tick();
      ack_once();
      check_val("dep_ack_valid", 32'(cmd_valid), 32'd0);
      check_val("dep_ack_busy",  32'(busy),      32'd0);

      // Simultaneous LOADPC and STEP
      swreg = 12'o0777; loadpc_p = 1; step_p = 1;
      tick();
      loadpc_p = 0; step_p = 0;
      tick();
      check_val("prio_op",  32'(cmd_op),   32'd1);
      check_val("prio_ovf", 32'(overflow), 32'd1);
      ack_once();
      tick();
      check_val("prio_busy", 32'(busy), 32'd0);

      // Five pulses, depth four, no ack: fifth dropped, order preserved
      do_reset();
      pulse(2, 12'o0001);
      pulse(3, 12'o0002);
      pulse(4, 12'o0003);
      pulse(1, 12'o0004);
      pulse(3, 12'o0005);
      check_val("full_ovf", 32'(overflow), 32'd1);
      for (int k = 0; k < 4; k++) begin
         wait_for_valid("full_wait");
         check_val("full_order", 32'(cmd_op), 32'(exp_ops[k]));
         ack_once();
      end
      tick();
      check_val("full_drained", 32'(busy), 32'd0);

      // Run, then a STEP preempts it through STOP
      do_reset();
      run = 1;
      tick();
      tick();
      check_val("run_go", 32'(cpu_go), 32'd1);
      pulse(4, 12'o4321);
      tick();
      check_val("stop_go", 32'(cpu_go), 32'd0);
      repeat (3) tick();
      check_val("stop_hold", 32'(cmd_valid), 32'd0);
      cpu_idle = 1;
      wait_for_valid("step_issue");
      check_val("step_op", 32'(cmd_op), 32'd4);
      ack_once();
      wait_for_go("run_resume");
      cpu_idle = 0;

      // Asynchronous reset mid-handshake, late ack ignored
      do_reset();
      pulse(2, 12'o7070);
      wait_for_valid("areset_wait");
      #2 resetN = 1'b0;
      #1;
      check_val("areset_valid", 32'(cmd_valid), 32'd0);
      check_val("areset_busy",  32'(busy),      32'd0);
      model_reset();
      tick();
      tick();
      resetN = 1'b1;
      ack_once();
      tick();
      check_val("late_ack_valid", 32'(cmd_valid), 32'd0);
      check_val("late_ack_busy",  32'(busy),      32'd0);

`ifdef PANEL_SEQ_TIMEOUT_EN
      // Watchdog aborts an unacknowledged command
      do_reset();
      pulse(2, 12'o0042);
      wait_for_valid("tmo_wait");
      repeat (TMO + 2) tick();
      check_val("tmo_flag",  32'(timeout),   32'd1);
      check_val("tmo_valid", 32'(cmd_valid), 32'd0);
      check_val("tmo_busy",  32'(busy),      32'd0);
`endif

      // Randomized traffic in phases with different pulse and ack rates
      do_reset();
      for (int ph = 0; ph < 6; ph++) begin
         for (int c = 0; c < 400; c++) begin
            loadpc_p  = ($urandom_range(99) < pulse_pct[ph] / 2);
            loadac_p  = ($urandom_range(99) < pulse_pct[ph] / 2);
            deposit_p = ($urandom_range(99) < pulse_pct[ph]);
            step_p    = ($urandom_range(99) < pulse_pct[ph]);
            swreg     = 12'($urandom);
            if ($urandom_range(99) < 4) run = ~run;
            cpu_idle  = ($urandom_range(99) < 50);
            cmd_ack   = ($urandom_range(99) < ack_pct[ph]);
            tick();
         end
      end
      clear_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/panel_cmd_sequencer.md
PANEL_CMD_SEQUENCER -- requirements
Module: panel_cmd_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, command queue depth; power of two, minimum 2.
REQ-002 Parameter: TIMEOUT_CYC, default 16, ack watchdog limit in clock cycles (used only under PANEL_SEQ_TIMEOUT_EN).
REQ-003 clock  in  1  system clock; all state changes on its rising edge.
REQ-004 resetN  in  1  reset, asynchronous, active-low.
REQ-005 loadpc_p, loadac_p, deposit_p, step_p  in  1 each  single-cycle debounced front-panel pulses.
REQ-006 swreg  in  12  switch register value.
REQ-007 run  in  1  panel run level.
REQ-008 cpu_idle  in  1  CPU is at an instruction boundary.
REQ-009 cmd_ack  in  1  CPU has completed the presented command.
REQ-010 cmd_valid  out  1  command presented to the CPU.
REQ-011 cmd_op  out  3  opcode: 001 LOADPC, 010 LOADAC, 011 DEPOSIT, 100 STEP, 000 none.
REQ-012 cmd_data  out  12  swreg captured at enqueue.
REQ-013 cpu_go  out  1  CPU is permitted to free-run.
REQ-014 busy  out  1  high when the FIFO is non-empty or state is not IDLE.
REQ-015 overflow  out  1  sticky flag: a pulse was dropped.
REQ-016 timeout  out  1  sticky flag: a command was aborted (PANEL_SEQ_TIMEOUT_EN only; otherwise tied 0).

Function
REQ-017 Enqueue: a pulse in cycle N writes {op, swreg} into the FIFO at edge N+1.
REQ-018 Simultaneous pulses: only the highest-priority pulse is enqueued (LOADPC > LOADAC > DEPOSIT > STEP); the others are dropped and overflow is set.
REQ-019 FIFO full: the incoming pulse is dropped, overflow is set, and FIFO contents are unchanged.
REQ-020 Simultaneous enqueue and pop: both take effect; the count is unchanged.
REQ-021 Pointers: wrap modulo FIFO_DEPTH.
REQ-022 FSM states: IDLE, CMD, RUN, STOP; encoded registers; no latches.
REQ-023 IDLE -> CMD when the FIFO is non-empty; the FIFO has priority over run.
REQ-024 IDLE -> RUN when the FIFO is empty and run=1.
REQ-025 CMD: cmd_valid=1; cmd_op/cmd_data equal the FIFO head and are stable until ack.
REQ-026 CMD, on cmd_ack=1: pop the head, then go to IDLE.
REQ-027 Latency: a pulse at cycle N, with the FIFO empty and state IDLE, gives cmd_valid high at cycle N+2.
REQ-028 Throughput: at most one command per two cycles, because the FSM returns to IDLE between commands.
REQ-029 RUN: cpu_go=1.
REQ-030 RUN -> STOP when run=0 or the FIFO becomes non-empty.
REQ-031 STOP: cpu_go=0; STOP -> IDLE when cpu_idle=1.
REQ-032 Pulses during RUN/STOP are enqueued and not issued until IDLE.
REQ-033 cmd_ack outside CMD is ignored.
REQ-034 cmd_valid and cpu_go are never high in the same cycle.
REQ-035 All outputs are registered, except busy (combinational from registers).

Reset
REQ-036 resetN low asynchronously forces: state IDLE; FIFO empty; cmd_valid=0; cmd_op=000; cmd_data=0; cpu_go=0; overflow=0; timeout=0.
REQ-037 Reset mid-handshake discards the pending command; no ack is awaited after release.
REQ-038 The first enqueue after reset release occurs on the edge following the first pulse.

Configuration
REQ-039 Macro PANEL_SEQ_TIMEOUT_EN defined: a counter runs in CMD and clears on entry to CMD.
REQ-040 With PANEL_SEQ_TIMEOUT_EN defined, on reaching TIMEOUT_CYC cycles without ack: pop the head, set timeout, go to IDLE.
REQ-041 Macro PANEL_SEQ_TIMEOUT_EN undefined: CMD waits indefinitely for ack; timeout is tied 0 and no counter logic is present.

Verification
REQ-042 deposit_p at cycle 10 with swreg=12'o1234 -> cmd_valid=1, cmd_op=011, cmd_data=12'o1234 at cycle 12; ack at 15 -> cmd_valid=0 at 16, busy=0 at 16.
REQ-043 loadpc_p and step_p in the same cycle -> only LOADPC is issued; overflow=1.
REQ-044 Five pulses with no ack (depth 4) -> first four are queued, fifth is dropped, overflow=1; four acks -> ops issued in arrival order.
REQ-045 run=1 with the FIFO empty -> cpu_go=1 two cycles later; step_p during RUN -> cpu_go=0, STOP, wait cpu_idle, then CMD STEP issued, then RUN resumes.
REQ-046 resetN low while cmd_valid=1 -> cmd_valid=0 and busy=0 immediately (asynchronous); a late ack after release is ignored.
REQ-047 PANEL_SEQ_TIMEOUT_EN defined, LOADAC with no ack -> after 16 cycles cmd_valid=0, timeout=1, FIFO count decrements.
